write_back: RTL and testbench
=============================

WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the pending-write queue depth (power of two, 2..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 wb_valid  input  1  SHALL flag a result bundle offered on wb_in this cycle.
REQ-005 wb_in  input  76  SHALL carry the result bundle:
- [7:0] control_rod, same encoding as the operand-fetch bundle
- [71:8] result data
- [75:72] destination register address
REQ-006 wb_ready  output  1  SHALL indicate the block accepts a bundle this cycle.
REQ-007 rf_busy  input  1  SHALL, when high, forbid a register-file write this cycle.
REQ-008 write_port_address  output  4, write_data  output  64, is_write  output  1 SHALL drive the register-file write port.
REQ-009 fwd_addr_a, fwd_addr_b  input  4 each SHALL be operand-fetch source addresses for forwarding lookup.
REQ-010 fwd_hit_a, fwd_hit_b  output  1 each, fwd_data_a, fwd_data_b  output  64 each SHALL return forwarding results.
REQ-011 writes_done  output  16  SHALL count completed register-file writes.

Function
REQ-012 A bundle SHALL be a "writing bundle" iff control_rod[0]|control_rod[1]|control_rod[2].
REQ-013 Handshake: a transfer SHALL occur on an edge where wb_valid && wb_ready are both high.
REQ-014 wb_ready SHALL be high iff count < DEPTH; it SHALL NOT depend on wb_valid or on a same-cycle pop.
REQ-015 A transferred writing bundle SHALL be enqueued at the tail with {address, data}.
REQ-016 A transferred non-writing bundle SHALL be discarded with no state change.
REQ-017 Pop: on an edge where count > 0 and rf_busy == 0, the head entry SHALL be removed and registered onto write_port_address/write_data with is_write = 1.
REQ-018 On any other edge, is_write SHALL be 0, and write_port_address/write_data SHALL hold their last values.
REQ-019 is_write SHALL therefore be high for exactly one cycle per entry.
REQ-020 Latency: a bundle transferred at edge N with rf_busy low SHALL appear on the write port in the cycle after edge N+1, given an empty queue. There SHALL be no same-cycle bypass.
REQ-021 Simultaneous push and pop SHALL both take effect, leaving count unchanged.
REQ-022 Head and tail pointers SHALL wrap modulo DEPTH; the order of writes SHALL be strictly FIFO.
REQ-023 Full: with count == DEPTH, wb_ready SHALL be low. A pop on that edge SHALL NOT admit a push on the same edge.
REQ-024 Empty: with count == 0, no pop SHALL occur regardless of rf_busy.
REQ-025 Writes to address 0 SHALL be performed like any other address.
REQ-026 Forwarding SHALL be combinational. fwd_hit_x SHALL be high iff fwd_addr_x matches any of:
- a valid queue entry
- the write-port entry while is_write is high
REQ-027 fwd_data_x SHALL be the data of the youngest matching entry. Youngest order SHALL be: queue tail-most first, then the write-port entry.
REQ-028 fwd_data_x SHALL be 0 when fwd_hit_x is low.
REQ-029 writes_done SHALL increment on each edge that sets is_write, and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-030 While rst_n is low, the following SHALL be cleared immediately, independent of clk:
- count, head and tail pointers
- is_write, write_port_address, write_data
- writes_done
REQ-031 While rst_n is low, wb_ready SHALL be high and all fwd_hit outputs SHALL be low.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries, and no write SHALL be issued for them.
REQ-033 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 Single write: push {ctrl=8'h01, data=64'hDEAD_BEEF, addr=4'h5}, rf_busy=0.
- is_write=1 with addr 5, data DEADBEEF for one cycle, two edges after the push.
- writes_done=1.
REQ-035 Non-writing bundle: push ctrl=8'h08.
- No is_write pulse.
- count stays 0, and wb_ready stays high.
REQ-036 Full/back-pressure: with rf_busy=1, push 5 writing bundles (addr 1..5).
- wb_ready drops after the 4th push, and the 5th is held.
- Release rf_busy: writes issue in order 1,2,3,4, one per cycle; the 5th is then accepted.
REQ-037 Forwarding priority: queue addr 3 with data 64'h11, then addr 3 with data 64'h22; set fwd_addr_a=3.
- hit_a=1 and data_a=64'h22.
- Once both are drained, hit_a=0 and data_a=0.
REQ-038 Reset mid-operation: queue 3 entries, then pulse rst_n low between edges.
- Outputs clear immediately.
- No further is_write pulses, and writes_done=0.
REQ-039 Counter wrap: preload writes_done to 16'hFFFF via 65535 writes, then perform one more write.
- writes_done=0.

Source files
------------

// File: rtl/write_back.sv
// Write-back stage: buffers result bundles in a small FIFO, drains them to the
// register-file write port when it is free, and serves operand forwarding.
module write_back #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_valid,
   input  logic [75:0] wb_in,
   output logic        wb_ready,
   input  logic        rf_busy,
   output logic [3:0]  write_port_address,
   output logic [63:0] write_data,
   output logic        is_write,
   input  logic [3:0]  fwd_addr_a,
   input  logic [3:0]  fwd_addr_b,
   output logic        fwd_hit_a,
   output logic        fwd_hit_b,
   output logic [63:0] fwd_data_a,
   output logic [63:0] fwd_data_b,
   output logic [15:0] writes_done
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [3:0]    r_addr_mem [DEPTH];
   logic [63:0]   r_data_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_is_write;
   logic [3:0]    r_wp_addr;
   logic [63:0]   r_wp_data;
   logic [15:0]   r_writes_done;

   logic          w_writing;
   logic          w_push;
   logic          w_pop;
   logic          w_hit_a;
   logic          w_hit_b;
   logic [63:0]   w_data_a;
   logic [63:0]   w_data_b;
   logic [PW-1:0] w_idx;
   logic          w_valid_e;
   logic          w_match_a;
   logic          w_match_b;

   // Ready depends only on the registered occupancy, never on this cycle's pop.
   assign w_writing = wb_in[0] | wb_in[1] | wb_in[2];
   assign wb_ready  = (r_count < CW'(DEPTH));
   assign w_push    = wb_valid & wb_ready & w_writing;
   assign w_pop     = (r_count != {CW{1'b0}}) & ~rf_busy;

   // Queue storage: payload only, validity is implied by head/count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_mem[r_tail] <= wb_in[75:72];
         r_data_mem[r_tail] <= wb_in[71:8];
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= {PW{1'b0}};
         r_tail  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1);
         end else begin
            r_tail <= r_tail;
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end else begin
            r_head <= r_head;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Register-file write port and completed-write counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_write    <= 1'b0;
         r_wp_addr     <= 4'd0;
         r_wp_data     <= 64'd0;
         r_writes_done <= 16'd0;
      end else begin
         r_is_write <= w_pop;
         if (w_pop) begin
            r_wp_addr     <= r_addr_mem[r_head];
            r_wp_data     <= r_data_mem[r_head];
            r_writes_done <= r_writes_done + 16'd1;
         end else begin
            r_wp_addr     <= r_wp_addr;
            r_wp_data     <= r_wp_data;
            r_writes_done <= r_writes_done;
         end
      end
   end

   // Forwarding: scan oldest to youngest so the youngest match wins.
   always_comb begin
      w_hit_a   = r_is_write & (r_wp_addr == fwd_addr_a);
      w_hit_b   = r_is_write & (r_wp_addr == fwd_addr_b);
      w_data_a  = w_hit_a ? r_wp_data : 64'd0;
      w_data_b  = w_hit_b ? r_wp_data : 64'd0;
      w_idx     = {PW{1'b0}};
      w_valid_e = 1'b0;
      w_match_a = 1'b0;
      w_match_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx     = r_head + PW'(i);
         w_valid_e = (CW'(i) < r_count);
         w_match_a = w_valid_e & (r_addr_mem[w_idx] == fwd_addr_a);
         w_match_b = w_valid_e & (r_addr_mem[w_idx] == fwd_addr_b);
         w_hit_a   = w_hit_a | w_match_a;
         w_hit_b   = w_hit_b | w_match_b;
         w_data_a  = w_match_a ? r_data_mem[w_idx] : w_data_a;
         w_data_b  = w_match_b ? r_data_mem[w_idx] : w_data_b;
      end
   end

   assign write_port_address = r_wp_addr;
   assign write_data         = r_wp_data;
   assign is_write           = r_is_write;
   assign writes_done        = r_writes_done;
   assign fwd_hit_a          = w_hit_a;
   assign fwd_hit_b          = w_hit_b;
   assign fwd_data_a         = w_data_a;
   assign fwd_data_b         = w_data_b;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_write_back;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        wb_valid;
   logic [75:0] wb_in;
   logic        wb_ready;
   logic        rf_busy;
   logic [3:0]  write_port_address;
   logic [63:0] write_data;
   logic        is_write;
   logic [3:0]  fwd_addr_a;
   logic [3:0]  fwd_addr_b;
   logic        fwd_hit_a;
   logic        fwd_hit_b;
   logic [63:0] fwd_data_a;
   logic [63:0] fwd_data_b;
   logic [15:0] writes_done;

   int checks;
   int errors;

   // reference model state
   logic [67:0] m_q[$];
   logic        m_is_write;
   logic [3:0]  m_addr;
   logic [63:0] m_data;
   logic [15:0] m_done;

   write_back #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_in(wb_in),
      .wb_ready(wb_ready), .rf_busy(rf_busy),
      .write_port_address(write_port_address), .write_data(write_data),
      .is_write(is_write), .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
      .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
      .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
      .writes_done(writes_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [75:0] bundle(input logic [3:0] a, input logic [63:0] d,
                                          input logic [7:0] c);
      return {a, d, c};
   endfunction

   // youngest queued entry first, then the write-port entry
   function automatic logic [64:0] fwd_model(input logic [3:0] a);
      for (int i = m_q.size() - 1; i >= 0; i--) begin
         if (m_q[i][67:64] == a) return {1'b1, m_q[i][63:0]};
      end
      if (m_is_write && m_addr == a) return {1'b1, m_data};
      return 65'd0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_is_write = 1'b0;
      m_addr     = 4'd0;
      m_data     = 64'd0;
      m_done     = 16'd0;
   endtask

   // advance one clock, updating the model from the inputs seen at the edge
   task automatic tick();
      bit push;
      bit pop;
      logic [67:0] head;
      @(posedge clk);
      if (rst_n) begin
         push = wb_valid && (m_q.size() < DEPTH) && (|wb_in[2:0]);
         pop  = (m_q.size() > 0) && !rf_busy;
         if (pop) begin
            head   = m_q.pop_front();
            m_addr = head[67:64];
            m_data = head[63:0];
            m_done = m_done + 16'd1;
         end
         m_is_write = pop;
         if (push) m_q.push_back({wb_in[75:72], wb_in[71:8]});
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wb_valid = 1'b0; wb_in = 76'd0; rf_busy = 1'b0;
      fwd_addr_a = 4'd0; fwd_addr_b = 4'd0;
      model_reset();
      #2;
      checks++;
      if (is_write !== 1'b0 || write_port_address !== 4'd0 || write_data !== 64'd0) begin
         errors++;
         $display("FAIL reset_port: is_write=%b addr=%h data=%h expected 0/0/0",
                  is_write, write_port_address, write_data);
      end
      checks++;
      if (wb_ready !== 1'b1 || fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_hit: ready=%b hit_a=%b hit_b=%b expected 1/0/0",
                  wb_ready, fwd_hit_a, fwd_hit_b);
      end
      checks++;
      if (writes_done !== 16'd0) begin
         errors++;
         $display("FAIL reset_done: got %h expected 0000", writes_done);
      end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      wb_valid = 1'b1;
      wb_in    = bundle(4'h5, 64'hDEAD_BEEF, 8'h01);
      rf_busy  = 1'b0;
      tick();
      wb_valid = 1'b0;
      checks++;
      if (is_write !== 1'b0) begin
         errors++;
         $display("FAIL single_no_bypass: is_write=%b expected 0", is_write);
      end
      tick();
      checks++;
      if (is_write !== 1'b1 || write_port_address !== 4'h5 || write_data !== 64'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_write: is_write=%b addr=%h data=%h expected 1/5/deadbeef",
                  is_write, write_port_address, write_data);
      end
      checks++;
      if (writes_done !== 16'd1) begin
         errors++;
         $display("FAIL single_done: got %0d expected 1", writes_done);
      end
      tick();
      checks++;
      if (is_write !== 1'b0 || write_port_address !== 4'h5) begin
         errors++;
         $display("FAIL single_one_pulse: is_write=%b addr=%h expected 0/5 (held)",
                  is_write, write_port_address);
      end
   endtask

   task automatic test_non_writing();
      wb_valid   = 1'b1;
      wb_in      = bundle(4'h9, 64'h1234, 8'h08);
      fwd_addr_a = 4'h9;
      tick();
      wb_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (is_write !== 1'b0 || wb_ready !== 1'b1 || fwd_hit_a !== 1'b0) begin
            errors++;
            $display("FAIL non_writing: is_write=%b ready=%b hit_a=%b expected 0/1/0",
                     is_write, wb_ready, fwd_hit_a);
         end
         tick();
      end
      checks++;
      if (writes_done !== 16'd1) begin
         errors++;
         $display("FAIL non_writing_done: got %0d expected 1", writes_done);
      end
   endtask

   task automatic test_full();
      logic [3:0] exp_addr [5];
      rf_busy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wb_valid = 1'b1;
         wb_in    = bundle(4'(k), 64'(k * 16), 8'h02);
         checks++;
         if (wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_before_%0d: got %b expected 1", k, wb_ready);
         end
         tick();
      end
      wb_in = bundle(4'h5, 64'h50, 8'h02);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (wb_ready !== 1'b0 || is_write !== 1'b0) begin
            errors++;
            $display("FAIL full_held: ready=%b is_write=%b expected 0/0", wb_ready, is_write);
         end
         tick();
      end
      rf_busy  = 1'b0;
      exp_addr = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 1) wb_valid = 1'b0;
         checks++;
         if (is_write !== 1'b1 || write_port_address !== exp_addr[k]) begin
            errors++;
            $display("FAIL full_order_%0d: is_write=%b addr=%h expected 1/%h",
                     k, is_write, write_port_address, exp_addr[k]);
         end
      end
      tick();
      checks++;
      if (is_write !== 1'b0 || wb_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_drained: is_write=%b ready=%b expected 0/1", is_write, wb_ready);
      end
   endtask

   task automatic test_forwarding();
      rf_busy    = 1'b1;
      fwd_addr_a = 4'h3;
      fwd_addr_b = 4'h7;
      wb_valid   = 1'b1;
      wb_in      = bundle(4'h3, 64'h11, 8'h01);
      tick();
      wb_in = bundle(4'h3, 64'h22, 8'h01);
      tick();
      wb_valid = 1'b0;
      #1;
      checks++;
      if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h22) begin
         errors++;
         $display("FAIL fwd_youngest: hit=%b data=%h expected 1/22", fwd_hit_a, fwd_data_a);
      end
      checks++;
      if (fwd_hit_b !== 1'b0 || fwd_data_b !== 64'd0) begin
         errors++;
         $display("FAIL fwd_miss: hit=%b data=%h expected 0/0", fwd_hit_b, fwd_data_b);
      end
      rf_busy = 1'b0;
      tick();
      checks++;
      if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h22) begin
         errors++;
         $display("FAIL fwd_queue_over_port: hit=%b data=%h expected 1/22", fwd_hit_a, fwd_data_a);
      end
      tick();
      checks++;
      if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h22) begin
         errors++;
         $display("FAIL fwd_port: hit=%b data=%h expected 1/22", fwd_hit_a, fwd_data_a);
      end
      tick();
      checks++;
      if (fwd_hit_a !== 1'b0 || fwd_data_a !== 64'd0) begin
         errors++;
         $display("FAIL fwd_drained: hit=%b data=%h expected 0/0", fwd_hit_a, fwd_data_a);
      end
   endtask

   task automatic test_random();
      logic [64:0] ea;
      logic [64:0] eb;
      for (int n = 0; n < 400; n++) begin
         wb_valid   = ($urandom_range(0, 3) != 0);
         wb_in      = bundle(4'($urandom_range(0, 3)), {$urandom, $urandom},
                             8'($urandom_range(0, 255)));
         rf_busy    = ($urandom_range(0, 9) < 4);
         fwd_addr_a = 4'($urandom_range(0, 3));
         fwd_addr_b = 4'($urandom_range(0, 4));
         #1;
         ea = fwd_model(fwd_addr_a);
         eb = fwd_model(fwd_addr_b);
         checks++;
         if (wb_ready !== (m_q.size() < DEPTH) || is_write !== m_is_write
             || writes_done !== m_done) begin
            errors++;
            $display("FAIL rand_ctrl_%0d: ready=%b is_write=%b done=%h expected %b/%b/%h",
                     n, wb_ready, is_write, writes_done, (m_q.size() < DEPTH),
                     m_is_write, m_done);
         end
         checks++;
         if (write_port_address !== m_addr || write_data !== m_data) begin
            errors++;
            $display("FAIL rand_port_%0d: addr=%h data=%h expected %h/%h",
                     n, write_port_address, write_data, m_addr, m_data);
         end
         checks++;
         if ({fwd_hit_a, fwd_data_a} !== ea || {fwd_hit_b, fwd_data_b} !== eb) begin
            errors++;
            $display("FAIL rand_fwd_%0d: a=%b/%h b=%b/%h expected a=%b/%h b=%b/%h", n,
                     fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b,
                     ea[64], ea[63:0], eb[64], eb[63:0]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      wb_valid = 1'b0;
      rf_busy  = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      wb_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wb_in = bundle(4'(k + 10), 64'(k + 100), 8'h01);
         tick();
      end
      wb_valid   = 1'b0;
      fwd_addr_a = 4'd12;
      #1;
      checks++;
      if (is_write !== 1'b1 || fwd_hit_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre_reset: is_write=%b hit_a=%b expected 1/1", is_write, fwd_hit_a);
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (is_write !== 1'b0 || write_port_address !== 4'd0 || write_data !== 64'd0
          || writes_done !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_clear: is_write=%b addr=%h data=%h done=%h expected zeros",
                  is_write, write_port_address, write_data, writes_done);
      end
      checks++;
      if (wb_ready !== 1'b1 || fwd_hit_a !== 1'b0 || fwd_data_a !== 64'd0) begin
         errors++;
         $display("FAIL mid_reset_ready_hit: ready=%b hit=%b data=%h expected 1/0/0",
                  wb_ready, fwd_hit_a, fwd_data_a);
      end
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (is_write !== 1'b0 || writes_done !== 16'd0) begin
            errors++;
            $display("FAIL mid_no_write_%0d: is_write=%b done=%h expected 0/0",
                     k, is_write, writes_done);
         end
      end
   endtask

   task automatic test_wrap();
      rf_busy  = 1'b0;
      wb_valid = 1'b1;
      for (int k = 0; k < 65535; k++) begin
         wb_in = bundle(4'($urandom_range(0, 15)), 64'(k), 8'h04);
         tick();
      end
      wb_valid = 1'b0;
      tick();
      checks++;
      if (writes_done !== 16'hFFFF || writes_done !== m_done) begin
         errors++;
         $display("FAIL wrap_preload: got %h expected ffff", writes_done);
      end
      wb_valid = 1'b1;
      wb_in    = bundle(4'h0, 64'hA5A5, 8'h01);
      tick();
      wb_valid = 1'b0;
      tick();
      checks++;
      if (writes_done !== 16'h0000 || is_write !== 1'b1 || write_port_address !== 4'h0
          || write_data !== 64'hA5A5) begin
         errors++;
         $display("FAIL wrap: done=%h is_write=%b addr=%h data=%h expected 0000/1/0/a5a5",
                  writes_done, is_write, write_port_address, write_data);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_write();
      test_non_writing();
      test_full();
      test_forwarding();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
